// File: rtl/cpu2_pkg.sv
// Shared definitions for the cpu2 core: opcodes, instruction field positions,
// sequencer states and opcode classification helpers.
package cpu2_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOADI = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_SHL   = 4'd7;
    localparam logic [3:0] OP_SHR   = 4'd8;
    localparam logic [3:0] OP_MOV   = 4'd9;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 8;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    // ALU ops are the only ones that update flags.
    function automatic logic op_is_alu(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SHR);
    endfunction

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_MOV) || (op == OP_HALT);
    endfunction

    function automatic logic op_writes(input logic [3:0] op);
        return (op == OP_LOADI) || (op == OP_MOV) || op_is_alu(op);
    endfunction

endpackage

// File: rtl/cpu2_if.sv
// Instruction handshake, writeback report, status and debug read port of cpu2_core.
interface cpu2_if #(
    parameter int DW = 16
);
    logic [15:0]   inst;
    logic          inst_valid;
    logic          inst_ready;
    logic          wb_valid;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic [2:0]    flags;
    logic          halted;
    logic          illegal;
    logic [2:0]    dbg_addr;
    logic [DW-1:0] dbg_data;

    modport master (
        output inst, inst_valid, dbg_addr,
        input  inst_ready, wb_valid, wb_addr, wb_data, flags, halted, illegal, dbg_data
    );

    modport slave (
        input  inst, inst_valid, dbg_addr,
        output inst_ready, wb_valid, wb_addr, wb_data, flags, halted, illegal, dbg_data
    );
endinterface

// File: rtl/cpu2_alu.sv
// Combinational ALU: add/sub/logic/shift on DW-bit operands with Z/N/C outputs.
module cpu2_alu
    import cpu2_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [3:0]    i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_result,
    output logic          o_z,
    output logic          o_n,
    output logic          o_c
);
    localparam int SHW = $clog2(DW);

    logic [DW:0]    w_wide;
    logic [DW:0]    w_shr;
    logic [SHW-1:0] w_amt;

    // The extra MSB of w_wide carries C: carry/borrow, or the last bit shifted out.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_wide = '0;
        w_amt  = i_b[SHW-1:0];
        w_shr  = {i_a, 1'b0} >> w_amt;
        case (i_op)
            OP_ADD:  w_wide = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB:  w_wide = {1'b0, i_a} - {1'b0, i_b};
            OP_AND:  w_wide = {1'b0, i_a & i_b};
            OP_OR:   w_wide = {1'b0, i_a | i_b};
            OP_XOR:  w_wide = {1'b0, i_a ^ i_b};
            OP_SHL:  w_wide = {1'b0, i_a} << w_amt;
            OP_SHR:  w_wide = {w_shr[0], w_shr[DW:1]};
            default: w_wide = '0;
        endcase
    end

    assign o_result = w_wide[DW-1:0];
    assign o_c      = w_wide[DW];
    assign o_z      = (o_result == '0);
    assign o_n      = o_result[DW-1];

endmodule

// File: rtl/cpu2_core.sv
// Multi-cycle 16-bit-instruction CPU: FETCH/DECODE/EXEC/WB sequencer, register
// file, sticky illegal detection, HALT and a combinational debug read port.
module cpu2_core
    import cpu2_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic  clk,
    input  logic  res,
    cpu2_if.slave bus
);
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    state_t        r_state;
    logic [15:0]   r_inst;
    logic [3:0]    r_op;
    logic [2:0]    r_rd;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_result;
    logic [2:0]    r_alu_flags;
    logic [2:0]    r_flags;
    logic          r_ready;
    logic          r_wb_valid;
    logic [2:0]    r_wb_addr;
    logic [DW-1:0] r_wb_data;
    logic          r_halted;
    logic          r_illegal;
    logic [DW-1:0] r_regs [NREG];

    logic [3:0]    w_op;
    logic [2:0]    w_rd;
    logic [2:0]    w_rs1;
    logic [2:0]    w_rs2;
    logic [DW-1:0] w_rs1_val;
    logic [DW-1:0] w_rs2_val;
    logic          w_bad_reg;
    logic          w_illegal_now;
    logic [DW-1:0] w_alu_result;
    logic          w_alu_z;
    logic          w_alu_n;
    logic          w_alu_c;

    function automatic logic idx_ok(input logic [2:0] idx);
        return int'(idx) < NREG;
    endfunction

    assign w_op  = r_inst[OP_MSB:OP_LSB];
    assign w_rd  = r_inst[RD_MSB:RD_LSB];
    assign w_rs1 = r_inst[RS1_MSB:RS1_LSB];
    assign w_rs2 = r_inst[RS2_MSB:RS2_LSB];

    assign w_rs1_val = idx_ok(w_rs1) ? r_regs[w_rs1[IW-1:0]] : '0;
    assign w_rs2_val = idx_ok(w_rs2) ? r_regs[w_rs2[IW-1:0]] : '0;

    // Only the register fields an opcode actually uses are range-checked.
    always_comb begin
        w_bad_reg = 1'b0;
        if (w_op == OP_LOADI)
            w_bad_reg = !idx_ok(w_rd);
        else if (w_op == OP_MOV)
            w_bad_reg = !idx_ok(w_rd) || !idx_ok(w_rs1);
        else if (op_is_alu(w_op))
            w_bad_reg = !idx_ok(w_rd) || !idx_ok(w_rs1) || !idx_ok(w_rs2);
    end

    assign w_illegal_now = !op_is_legal(w_op) || w_bad_reg;

    cpu2_alu #(.DW(DW)) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_z      (w_alu_z),
        .o_n      (w_alu_n),
        .o_c      (w_alu_c)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!res) begin
            r_state     <= S_FETCH;
            r_inst      <= '0;
            r_op        <= OP_NOP;
            r_rd        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_alu_flags <= '0;
            r_flags     <= '0;
            r_ready     <= 1'b1;
            r_wb_valid  <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_halted    <= 1'b0;
            r_illegal   <= 1'b0;
            // NOTE: the register file is architecturally zeroed by reset, so it is built from flops, not RAM.
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (bus.inst_valid) begin
                        r_inst  <= bus.inst;
                        r_ready <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_op    <= w_illegal_now ? OP_NOP : w_op;
                    r_rd    <= w_rd;
                    r_a     <= w_rs1_val;
                    r_b     <= w_rs2_val;
                    r_state <= S_EXEC;
                    if (w_illegal_now) r_illegal <= 1'b1;
                end
                S_EXEC: begin
                    case (r_op)
                        OP_LOADI: r_result <= DW'(r_inst[IMM_MSB:IMM_LSB]);
                        OP_MOV:   r_result <= r_a;
                        default:  r_result <= w_alu_result;
                    endcase
                    r_alu_flags <= {w_alu_z, w_alu_n, w_alu_c};
                    r_state     <= S_WB;
                end
                S_WB: begin
                    if (op_writes(r_op)) begin
                        r_regs[r_rd[IW-1:0]] <= r_result;
                        r_wb_valid <= 1'b1;
                        r_wb_addr  <= r_rd;
                        r_wb_data  <= r_result;
                    end
                    if (op_is_alu(r_op)) r_flags <= r_alu_flags;
                    if (r_op == OP_HALT) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALTED;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_HALTED: begin
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign bus.inst_ready = r_ready;
    assign bus.wb_valid   = r_wb_valid;
    assign bus.wb_addr    = r_wb_addr;
    assign bus.wb_data    = r_wb_data;
    assign bus.flags      = r_flags;
    assign bus.halted     = r_halted;
    assign bus.illegal    = r_illegal;
    assign bus.dbg_data   = idx_ok(bus.dbg_addr) ? r_regs[bus.dbg_addr[IW-1:0]] : '0;

endmodule

// File: tb/tb_cpu2_core.sv
// Drives identical instruction streams into an 8-register and a 4-register core
// and compares both against an architectural model of the instruction set.
module tb_cpu2_core;
    localparam int DW = 16;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic [15:0] tb_inst = '0;
    logic        tb_valid = 1'b0;
    logic [2:0]  tb_dbg = '0;

    always #10 clk = ~clk;

    cpu2_if #(.DW(DW)) bus8 ();
    cpu2_if #(.DW(DW)) bus4 ();

    assign bus8.inst       = tb_inst;
    assign bus8.inst_valid = tb_valid;
    assign bus8.dbg_addr   = tb_dbg;
    assign bus4.inst       = tb_inst;
    assign bus4.inst_valid = tb_valid;
    assign bus4.dbg_addr   = tb_dbg;

    cpu2_core #(.DW(DW), .NREG(8)) u_dut8 (.clk(clk), .res(res), .bus(bus8));
    cpu2_core #(.DW(DW), .NREG(4)) u_dut4 (.clk(clk), .res(res), .bus(bus4));

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int wb_cnt8     = 0;
    int last_accept = 0;

    always @(posedge clk) begin
        cycle++;
        if (bus8.wb_valid === 1'b1) wb_cnt8++;
    end

    // Architectural state per instance: index 0 has 8 registers, index 1 has 4.
    logic [15:0] m_r [2][8];
    logic [2:0]  m_flags [2];
    bit          m_halted [2];
    bit          m_illegal [2];
    int          m_nreg [2] = '{8, 4};

    function automatic logic [15:0] rtype(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] loadi(input logic [2:0] rd, input logic [8:0] imm);
        return {4'd1, rd, imm};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) m_r[k][i] = '0;
            m_flags[k]   = '0;
            m_halted[k]  = 0;
            m_illegal[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic [15:0] ins, output bit wb,
                              output logic [2:0] addr, output logic [15:0] data);
        int op, rd, rs1, rs2, n, amt;
        longint unsigned a, b, s;
        bit c, bad;
        op = int'(ins[15:12]); rd = int'(ins[11:9]); rs1 = int'(ins[8:6]); rs2 = int'(ins[5:3]);
        n = m_nreg[k];
        wb = 0; addr = '0; data = '0; c = 0; s = 0;
        if (op == 15) begin m_halted[k] = 1; return; end
        if (op >= 10) begin m_illegal[k] = 1; return; end
        if (op == 0) return;
        bad = (rd >= n) || (op != 1 && rs1 >= n) || (op >= 2 && op <= 8 && rs2 >= n);
        if (bad) begin m_illegal[k] = 1; return; end
        a = longint'(m_r[k][rs1]);
        b = longint'(m_r[k][rs2]);
        if (op == 1) s = longint'(ins[8:0]);
        else if (op == 9) s = a;
        else begin
            amt = int'(b % 16);
            case (op)
                2: begin s = (a + b) % 65536; c = (a + b) >= 65536; end
                3: begin s = (a + 65536 - b) % 65536; c = a < b; end
                4: s = a & b;
                5: s = a | b;
                6: s = a ^ b;
                7: begin s = (a << amt) % 65536; c = (amt != 0) && (((a >> (16 - amt)) % 2) == 1); end
                default: begin s = a >> amt; c = (amt != 0) && (((a >> (amt - 1)) % 2) == 1); end
            endcase
            m_flags[k] = {s == 0, s >= 32768, c};
        end
        m_r[k][rd] = s[15:0];
        wb = 1; addr = 3'(rd); data = s[15:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tb_valid = 0;
        res = 0;
        tick();
        tick();
        res = 1;
        model_reset();
    endtask

    task automatic check_regs();
        logic [15:0] want4;
        for (int i = 0; i < 8; i++) begin
            tb_dbg = 3'(i);
            #1;
            vectors++;
            if (bus8.dbg_data !== m_r[0][i]) begin
                miscompares++;
                $display("FAIL dbg8_r%0d: got %h want %h", i, bus8.dbg_data, m_r[0][i]);
            end
            want4 = (i < 4) ? m_r[1][i] : 16'h0000;
            vectors++;
            if (bus4.dbg_data !== want4) begin
                miscompares++;
                $display("FAIL dbg4_r%0d: got %h want %h", i, bus4.dbg_data, want4);
            end
        end
    endtask

    task automatic peek8(input logic [2:0] idx, input logic [15:0] want, input string name);
        tb_dbg = idx;
        #1;
        vectors++;
        if (bus8.dbg_data !== want) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, bus8.dbg_data, want);
        end
    endtask

    // Presents one instruction, waits for the accept, then checks the 3-cycle
    // writeback latency and the resulting architectural state. Returns at T+3.
    task automatic issue(input logic [15:0] ins, input bit hold);
        bit          wb [2];
        logic [2:0]  wa [2];
        logic [15:0] wd [2];
        logic        got_v, got_rdy, got_h, got_ill;
        logic [2:0]  got_a, got_f;
        logic [15:0] got_d;
        int          waited;
        for (int k = 0; k < 2; k++) model_step(k, ins, wb[k], wa[k], wd[k]);
        tb_inst = ins;
        tb_valid = 1;
        waited = 0;
        while (bus8.inst_ready !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        vectors++;
        if (bus8.inst_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_timeout: inst_ready %b want 1", bus8.inst_ready);
            tb_valid = 0;
            return;
        end
        tick();
        last_accept = cycle;
        if (!hold) begin
            tb_valid = 0;
            tb_inst = 16'($urandom);
        end
        vectors++;
        if (bus8.inst_ready !== 1'b0 || bus4.inst_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_busy: got %b/%b want 0/0", bus8.inst_ready, bus4.inst_ready);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus8.wb_valid !== 1'b0 || bus4.wb_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL wb_early c%0d: got %b/%b want 0/0", i, bus8.wb_valid, bus4.wb_valid);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            got_v   = (k == 0) ? bus8.wb_valid   : bus4.wb_valid;
            got_a   = (k == 0) ? bus8.wb_addr    : bus4.wb_addr;
            got_d   = (k == 0) ? bus8.wb_data    : bus4.wb_data;
            got_f   = (k == 0) ? bus8.flags      : bus4.flags;
            got_h   = (k == 0) ? bus8.halted     : bus4.halted;
            got_ill = (k == 0) ? bus8.illegal    : bus4.illegal;
            got_rdy = (k == 0) ? bus8.inst_ready : bus4.inst_ready;
            vectors++;
            if (got_v !== wb[k]) begin
                miscompares++;
                $display("FAIL wb_valid[%0d] ins=%h: got %b want %b", k, ins, got_v, wb[k]);
            end
            if (wb[k]) begin
                vectors++;
                if (got_a !== wa[k] || got_d !== wd[k]) begin
                    miscompares++;
                    $display("FAIL wb_addr_data[%0d] ins=%h: got %0d:%h want %0d:%h",
                             k, ins, got_a, got_d, wa[k], wd[k]);
                end
            end
            vectors++;
            if (got_f !== m_flags[k]) begin
                miscompares++;
                $display("FAIL flags[%0d] ins=%h: got %b want %b", k, ins, got_f, m_flags[k]);
            end
            vectors++;
            if (got_ill !== m_illegal[k] || got_h !== m_halted[k] || got_rdy !== !m_halted[k]) begin
                miscompares++;
                $display("FAIL status[%0d] ins=%h: got ill=%b h=%b rdy=%b want ill=%b h=%b rdy=%b",
                         k, ins, got_ill, got_h, got_rdy, m_illegal[k], m_halted[k], !m_halted[k]);
            end
        end
    endtask

    task automatic test_reset();
        res = 0;
        tick();
        tick();
        model_reset();
        vectors++;
        if (bus8.inst_ready !== 1'b1 || bus8.wb_valid !== 1'b0 || bus8.wb_addr !== 3'd0 ||
            bus8.wb_data !== 16'h0 || bus8.flags !== 3'b000 || bus8.halted !== 1'b0 ||
            bus8.illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b wbv=%b wba=%0d wbd=%h f=%b h=%b ill=%b want 1 0 0 0000 000 0 0",
                     bus8.inst_ready, bus8.wb_valid, bus8.wb_addr, bus8.wb_data, bus8.flags,
                     bus8.halted, bus8.illegal);
        end
        check_regs();
        res = 1;
    endtask

    task automatic test_basic();
        int w0;
        do_reset();
        w0 = wb_cnt8;
        issue(loadi(3'd1, 9'd6), 0);
        issue(loadi(3'd2, 9'd3), 0);
        issue(rtype(4'd2, 3'd3, 3'd1, 3'd2), 0);
        peek8(3'd3, 16'd9, "basic_add_r3");
        issue(rtype(4'd3, 3'd3, 3'd3, 3'd1), 0);
        peek8(3'd3, 16'd3, "basic_sub_r3");
        vectors++;
        if (bus8.flags !== 3'b000) begin
            miscompares++;
            $display("FAIL basic_flags: got %b want 000", bus8.flags);
        end
        tick();
        tick();
        vectors++;
        if (wb_cnt8 - w0 !== 4) begin
            miscompares++;
            $display("FAIL basic_wb_count: got %0d want 4", wb_cnt8 - w0);
        end
    endtask

    task automatic test_carry();
        do_reset();
        issue(loadi(3'd1, 9'h1FF), 0);
        issue(loadi(3'd2, 9'd7), 0);
        issue(rtype(4'd7, 3'd1, 3'd1, 3'd2), 0);
        peek8(3'd1, 16'hFF80, "shl_r1");
        // 0x1FF<<7 fits in 16 bits; the last bit shifted out is original bit 9, which is 0.
        vectors++;
        if (bus8.flags !== 3'b010) begin
            miscompares++;
            $display("FAIL shl_flags: got %b want 010", bus8.flags);
        end
        issue(rtype(4'd2, 3'd1, 3'd1, 3'd1), 0);
        peek8(3'd1, 16'hFF00, "add_r1");
        vectors++;
        if (bus8.flags !== 3'b011) begin
            miscompares++;
            $display("FAIL add_flags: got %b want 011", bus8.flags);
        end
        issue(rtype(4'd3, 3'd4, 3'd0, 3'd0), 0);
        vectors++;
        if (bus8.flags !== 3'b100) begin
            miscompares++;
            $display("FAIL sub_zero_flags: got %b want 100", bus8.flags);
        end
        check_regs();
    endtask

    task automatic test_back_to_back();
        int w0, a1, a2, a3;
        do_reset();
        w0 = wb_cnt8;
        issue(loadi(3'd5, 9'h0A), 1);
        a1 = last_accept;
        issue(loadi(3'd6, 9'h03), 1);
        a2 = last_accept;
        issue(rtype(4'd6, 3'd7, 3'd5, 3'd6), 1);
        a3 = last_accept;
        tb_valid = 0;
        vectors++;
        if (a2 - a1 !== 4 || a3 - a2 !== 4) begin
            miscompares++;
            $display("FAIL accept_spacing: got %0d,%0d want 4,4", a2 - a1, a3 - a2);
        end
        repeat (6) tick();
        vectors++;
        if (wb_cnt8 - w0 !== 3 || bus8.inst_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_wb_count: got %0d rdy=%b want 3 rdy=1", wb_cnt8 - w0, bus8.inst_ready);
        end
        peek8(3'd7, 16'h0009, "b2b_xor_r7");
        check_regs();
    endtask

    task automatic test_illegal();
        do_reset();
        issue(loadi(3'd1, 9'h21), 0);
        issue(loadi(3'd2, 9'h13), 0);
        issue(rtype(4'd3, 3'd3, 3'd2, 3'd1), 0);
        issue(rtype(4'd2, 3'd5, 3'd1, 3'd2), 0);
        vectors++;
        if (bus4.illegal !== 1'b1 || bus8.illegal !== 1'b0 || bus4.flags !== 3'b011) begin
            miscompares++;
            $display("FAIL illegal_reg: got ill4=%b ill8=%b f4=%b want 1 0 011",
                     bus4.illegal, bus8.illegal, bus4.flags);
        end
        issue(rtype(4'd12, 3'd1, 3'd1, 3'd1), 0);
        vectors++;
        if (bus8.illegal !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_op: got %b want 1", bus8.illegal);
        end
        issue(loadi(3'd1, 9'd5), 0);
        vectors++;
        if (bus8.illegal !== 1'b1 || bus4.illegal !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_sticky: got %b/%b want 1/1", bus8.illegal, bus4.illegal);
        end
        check_regs();
    endtask

    task automatic test_halt();
        int w0;
        do_reset();
        issue(loadi(3'd1, 9'd1), 0);
        issue(16'hF000, 0);
        w0 = wb_cnt8;
        tb_inst = loadi(3'd2, 9'd7);
        tb_valid = 1;
        for (int i = 0; i < 12; i++) begin
            vectors++;
            if (bus8.inst_ready !== 1'b0 || bus8.halted !== 1'b1) begin
                miscompares++;
                $display("FAIL halted_hold c%0d: got rdy=%b h=%b want 0 1", i, bus8.inst_ready, bus8.halted);
            end
            tick();
        end
        vectors++;
        if (wb_cnt8 !== w0) begin
            miscompares++;
            $display("FAIL halted_no_wb: got %0d want %0d", wb_cnt8, w0);
        end
        peek8(3'd2, 16'h0000, "halted_r2");
        tb_valid = 0;
        res = 0;
        tick();
        res = 1;
        model_reset();
        vectors++;
        if (bus8.halted !== 1'b0 || bus8.inst_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_reset: got h=%b rdy=%b want 0 1", bus8.halted, bus8.inst_ready);
        end
        check_regs();
    endtask

    task automatic test_reset_midop();
        int w0;
        do_reset();
        w0 = wb_cnt8;
        tb_inst = loadi(3'd3, 9'h055);
        tb_valid = 1;
        tick();
        tb_valid = 0;
        tick();
        res = 0;
        tick();
        res = 1;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (bus8.wb_valid !== 1'b0 || bus8.inst_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL midop c%0d: got wbv=%b rdy=%b want 0 1", i, bus8.wb_valid, bus8.inst_ready);
            end
            tick();
        end
        vectors++;
        if (wb_cnt8 !== w0) begin
            miscompares++;
            $display("FAIL midop_wb_count: got %0d want %0d", wb_cnt8, w0);
        end
        model_reset();
        peek8(3'd3, 16'h0000, "midop_r3");
    endtask

    task automatic test_random();
        logic [3:0] op;
        int gap;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(10, 14));
            else op = 4'($urandom_range(0, 9));
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                tb_valid = 0;
                tb_inst = 16'($urandom);
                repeat (gap) tick();
            end
            issue({op, 12'($urandom)}, $urandom_range(0, 1) == 1);
            if (n % 10 == 9) check_regs();
        end
        tb_valid = 0;
        tick();
        check_regs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_illegal();
        test_halt();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
